// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, predecodes hits, buffers them in a queue.
// Optional backward-taken branch prediction is enabled with IFU_BTFN_PREDICT_EN.
module inst_fetch_unit #(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic [31:0] pc,
    output logic        inst_req,
    input  logic        inst_ready,
    input  logic [31:0] inst_res,
    input  logic        clear,
    input  logic [31:0] clear_pc,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    output logic        iq_pred_taken,
    output logic [31:0] iq_pred_pc,
    input  logic        iq_pop
);

    localparam int AW = $clog2(IQ_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(IQ_DEPTH);
    localparam logic [6:0] OP_JAL = 7'b1101111;
`ifdef IFU_BTFN_PREDICT_EN
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`endif

    typedef enum logic {RUN, REDIRECT} state_t;

    state_t state, state_nxt;

    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [31:0]   q_inst  [IQ_DEPTH];
    logic [31:0]   q_pc    [IQ_DEPTH];
    logic [31:0]   q_pred  [IQ_DEPTH];
    logic          q_taken [IQ_DEPTH];

    logic        full;
    logic        push;
    logic        pop;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [31:0] imm_j;
`ifdef IFU_BTFN_PREDICT_EN
    logic [31:0] imm_b;
`endif

    assign full     = (count == FULL_CNT);
    assign iq_valid = (count != '0);
    assign push     = inst_req && inst_ready;
    assign pop      = rdy_in && !clear && iq_pop && iq_valid;

    assign iq_inst       = q_inst[head];
    assign iq_pc         = q_pc[head];
    assign iq_pred_taken = q_taken[head];
    assign iq_pred_pc    = q_pred[head];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // REDIRECT holds requests off for one cycle so the memory unit can drop its fill.
    always_comb begin
        state_nxt = state;
        inst_req  = 1'b0;
        if (rdy_in) begin
            unique case (state)
                RUN:      inst_req = !full && !clear;
                REDIRECT: state_nxt = RUN;
                default:  state_nxt = RUN;
            endcase
            if (clear) begin
                state_nxt = REDIRECT;
            end
        end
    end

    assign imm_j = {{12{inst_res[31]}}, inst_res[19:12], inst_res[20],
                    inst_res[30:21], 1'b0};
`ifdef IFU_BTFN_PREDICT_EN
    assign imm_b = {{20{inst_res[31]}}, inst_res[7], inst_res[30:25],
                    inst_res[11:8], 1'b0};
`endif

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc + 32'd4;
        if (inst_res[6:0] == OP_JAL) begin
            pred_taken = 1'b1;
            pred_pc    = pc + imm_j;
        end
`ifdef IFU_BTFN_PREDICT_EN
        else if (inst_res[6:0] == OP_BRANCH && inst_res[31]) begin
            pred_taken = 1'b1;
            pred_pc    = pc + imm_b;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (clear) begin
                pc    <= clear_pc;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    pc   <= pred_pc;
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (!push && pop) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                q_inst[i]  <= '0;
                q_pc[i]    <= '0;
                q_pred[i]  <= '0;
                q_taken[i] <= 1'b0;
            end
        end else if (push && !clear) begin
            q_inst[tail]  <= inst_res;
            q_pc[tail]    <= pc;
            q_pred[tail]  <= pred_pc;
            q_taken[tail] <= pred_taken;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized scoreboard bench for inst_fetch_unit.
// Expected queue entries come from an offset-to-encoding instruction generator.
module tb_inst_fetch_unit;

    localparam int          IQ_DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic [31:0] pc;
    logic        inst_req;
    logic        inst_ready;
    logic [31:0] inst_res;
    logic        clear;
    logic [31:0] clear_pc;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_pred_taken;
    logic [31:0] iq_pred_pc;
    logic        iq_pop;

    inst_fetch_unit #(.IQ_DEPTH(IQ_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .rdy_in(rdy_in),
        .pc(pc),
        .inst_req(inst_req),
        .inst_ready(inst_ready),
        .inst_res(inst_res),
        .clear(clear),
        .clear_pc(clear_pc),
        .iq_valid(iq_valid),
        .iq_inst(iq_inst),
        .iq_pc(iq_pc),
        .iq_pred_taken(iq_pred_taken),
        .iq_pred_pc(iq_pred_pc),
        .iq_pop(iq_pop)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        taken;
    } ent_t;

    ent_t        sb[$];
    logic [31:0] m_pc;
    logic        m_redir;
    int          n_tests;
    int          n_fail;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [31:0] enc_jal(logic [20:0] off);
        return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(logic [12:0] off);
        return {off[12], off[10:5], 5'd2, 5'd3, 3'b000, off[4:1], off[11],
                7'b1100011};
    endfunction

    // kind: 0 JAL, 1 conditional branch, 2 JALR, other = plain instruction
    task automatic gen_word(input int kind, input int o, output logic [31:0] w,
                            output logic tk, output logic [31:0] off);
        logic [31:0] r;
        logic [6:0]  ops [6];
        ops = '{7'b0010011, 7'b0110011, 7'b0000011,
                7'b0100011, 7'b0110111, 7'b0010111};
        r   = $urandom();
        tk  = 1'b0;
        off = 32'd4;
        case (kind)
            0: begin
                w   = enc_jal(21'(o));
                tk  = 1'b1;
                off = 32'(o);
            end
            1: begin
                w = enc_br(13'(o));
`ifdef IFU_BTFN_PREDICT_EN
                if (o < 0) begin
                    tk  = 1'b1;
                    off = 32'(o);
                end
`endif
            end
            2: w = {r[31:7], 7'b1100111};
            default: w = {r[31:7], ops[$urandom_range(0, 5)]};
        endcase
    endtask

    task automatic step(input logic r, input logic h, input logic [31:0] w,
                        input logic tk, input logic [31:0] off,
                        input logic c, input logic [31:0] cp, input logic p);
        logic exp_req;
        @(negedge clk_in);
        rdy_in     = r;
        inst_ready = h;
        inst_res   = w;
        clear      = c;
        clear_pc   = cp;
        iq_pop     = p;
        #1;
        exp_req = r && !m_redir && (sb.size() < IQ_DEPTH) && !c;
        chk("pc", pc, m_pc);
        chk("inst_req", 32'(inst_req), 32'(exp_req));
        chk("iq_valid", 32'(iq_valid), 32'(sb.size() != 0));
        if (r) begin
            if (c) begin
                sb.delete();
                m_pc    = cp;
                m_redir = 1'b1;
            end else begin
                m_redir = 1'b0;
                if (exp_req && h) begin
                    sb.push_back('{inst: w, pc: m_pc, pred: m_pc + off,
                                   taken: tk});
                    m_pc = m_pc + off;
                end
            end
        end
    endtask

    task automatic hit_plain(input logic p);
        logic [31:0] w, off;
        logic        tk;
        gen_word(3, 0, w, tk, off);
        step(1'b1, 1'b1, w, tk, off, 1'b0, 32'h0, p);
    endtask

    task automatic idle(input logic p);
        step(1'b1, 1'b0, 32'h13, 1'b0, 32'd4, 1'b0, 32'h0, p);
    endtask

    task automatic redirect(input logic [31:0] target);
        step(1'b1, 1'b1, 32'h13, 1'b0, 32'd4, 1'b1, target, 1'b0);
        idle(1'b0);
    endtask

    task automatic check_reset_vals(string tag);
        chk({tag, "_pc"}, pc, RESET_PC);
        chk({tag, "_req"}, 32'(inst_req), 32'h0);
        chk({tag, "_valid"}, 32'(iq_valid), 32'h0);
        chk({tag, "_inst"}, iq_inst, 32'h0);
        chk({tag, "_ipc"}, iq_pc, 32'h0);
        chk({tag, "_taken"}, 32'(iq_pred_taken), 32'h0);
        chk({tag, "_pred"}, iq_pred_pc, 32'h0);
    endtask

    // Monitor: consumes the scoreboard whenever the decoder pops a valid head.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk_in);
            #2;
            if (rst_n_in && rdy_in && !clear && iq_pop && iq_valid) begin
                if (sb.size() == 0) begin
                    chk("pop_on_empty_model", 32'(iq_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("head_inst", iq_inst, e.inst);
                    chk("head_pc", iq_pc, e.pc);
                    chk("head_pred_pc", iq_pred_pc, e.pred);
                    chk("head_taken", 32'(iq_pred_taken), 32'(e.taken));
                end
            end
        end
    end

    initial begin
        logic [31:0] w, off, t;
        logic        tk;
        int          kind, o;
        n_tests    = 0;
        n_fail     = 0;
        rst_n_in   = 1'b0;
        rdy_in     = 1'b0;
        inst_ready = 1'b0;
        inst_res   = 32'h0;
        clear      = 1'b0;
        clear_pc   = 32'h0;
        iq_pop     = 1'b0;
        m_pc       = RESET_PC;
        m_redir    = 1'b0;
        #2;
        check_reset_vals("reset");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        for (int i = 0; i < 5; i++) hit_plain(1'b0);
        hit_plain(1'b1);
        hit_plain(1'b0);
        chk("fill_resume_pc", pc, 32'h10);
        chk("fill_resume_req", 32'(inst_req), 32'h1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        redirect(32'h100);
        gen_word(0, 32'h40, w, tk, off);
        step(1'b1, 1'b1, w, tk, off, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
        chk("jal_next_pc", pc, 32'h140);
        chk("jal_head_taken", 32'(iq_pred_taken), 32'h1);
        chk("jal_head_pred", iq_pred_pc, 32'h140);

        redirect(32'h200);
        gen_word(1, -8, w, tk, off);
        step(1'b1, 1'b1, w, tk, off, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
`ifdef IFU_BTFN_PREDICT_EN
        chk("bwd_branch_pc", pc, 32'h1F8);
        chk("bwd_branch_taken", 32'(iq_pred_taken), 32'h1);
`else
        chk("bwd_branch_pc", pc, 32'h204);
        chk("bwd_branch_taken", 32'(iq_pred_taken), 32'h0);
`endif

        redirect(32'h300);
        for (int i = 0; i < 3; i++) hit_plain(1'b0);
        step(1'b1, 1'b1, 32'h13, 1'b0, 32'd4, 1'b1, 32'h80, 1'b0);
        idle(1'b0);
        chk("clr_valid", 32'(iq_valid), 32'h0);
        chk("clr_req_off", 32'(inst_req), 32'h0);
        idle(1'b0);
        chk("clr_req_on", 32'(inst_req), 32'h1);
        chk("clr_pc", pc, 32'h80);

        hit_plain(1'b0);
        for (int i = 0; i < 10; i++) idle(1'b0);
        hit_plain(1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'h13, 1'b0, 32'd4, i[0], 32'h40, 1'b1);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        redirect(32'hFFFF_FFFC);
        hit_plain(1'b0);
        idle(1'b1);
        chk("wrap_pc", pc, 32'h0);

        for (int i = 0; i < 2000; i++) begin
            kind = $urandom_range(0, 3);
            o    = (kind == 0) ? int'($urandom_range(0, 1048575)) * 2 - 1048576
                               : int'($urandom_range(0, 4095)) * 2 - 4096;
            gen_word(kind, o, w, tk, off);
            t = $urandom();
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 w, tk, off, $urandom_range(0, 24) == 0, {t[31:2], 2'b00},
                 $urandom_range(0, 2) != 0);
            if (i == 1000) begin
                for (int k = 0; k < 3; k++) hit_plain(1'b0);
                @(negedge clk_in);
                rdy_in = 1'b0;
                iq_pop = 1'b0;
                clear  = 1'b0;
                #3;
                rst_n_in = 1'b0;
                #1;
                check_reset_vals("async_rst");
                @(negedge clk_in);
                rst_n_in = 1'b1;
                sb.delete();
                m_pc    = RESET_PC;
                m_redir = 1'b0;
                hit_plain(1'b0);
            end
        end

        @(negedge clk_in);
        rdy_in = 1'b0;
        iq_pop = 1'b0;
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
